// File: rtl/gdiv_if.sv
// Handshake and operand bundle for the Goldschmidt divider.
// The master drives the operands and start/en. The slave returns busy/done/result.
interface gdiv_if #(parameter int WIDTH = 32);
   logic             en;
   logic             start;
   logic [WIDTH-1:0] N;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] IA;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output en, start, N, D, IA, input busy, done, result);
   modport slave  (input en, start, N, D, IA, output busy, done, result);
endinterface

// File: rtl/gdiv_datapath.sv
// Iterative Goldschmidt divider with one shared WIDTHxWIDTH multiplier.
// Each iteration takes two cycles: N*K, then D*K with K refreshed to 2-D.
module gdiv_datapath #(
   parameter int WIDTH = 32,
   parameter int ITERS = 3
) (
   input  logic   clk,
   input  logic   reset,
   gdiv_if.slave  bus
);
   localparam int CW = $clog2(ITERS + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL_N, S_MUL_D, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_nr, r_dr, r_kr, r_result;
   logic [CW-1:0]    r_cnt;
   logic             w_load, w_last;
   logic [WIDTH-1:0] w_opa, w_mul, w_knext;
   logic             w_unused_hi;
   logic [WIDTH-2:0] w_unused_lo;

   // Q1 x Q1 gives Q2; keep the Q1 window and drop the overflow bit and the fraction tail.
   assign w_opa   = (r_state == S_MUL_N) ? r_nr : r_dr;
   assign {w_unused_hi, w_mul, w_unused_lo} =
      {{WIDTH{1'b0}}, w_opa} * {{WIDTH{1'b0}}, r_kr};
   assign w_knext = -w_mul;
   assign w_last  = (r_cnt + CW'(1)) == CW'(ITERS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      if (bus.en) begin
         case (r_state)
            S_IDLE: if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = S_MUL_N;
            end
            S_MUL_N: w_state_nxt = S_MUL_D;
            S_MUL_D: w_state_nxt = w_last ? S_DONE : S_MUL_N;
            S_DONE: begin
               w_load      = bus.start;
               w_state_nxt = bus.start ? S_MUL_N : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_nr     <= '0;
         r_dr     <= '0;
         r_kr     <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (bus.en) begin
         if (w_load) begin
            r_nr  <= bus.N;
            r_dr  <= bus.D;
            r_kr  <= bus.IA;
            r_cnt <= '0;
         end else if (r_state == S_MUL_N) begin
            r_nr <= w_mul;
         end else if (r_state == S_MUL_D) begin
            r_dr  <= w_mul;
            r_kr  <= w_knext;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_result <= r_nr;
         end
      end
   end

   assign bus.busy   = (r_state == S_MUL_N) || (r_state == S_MUL_D);
   assign bus.done   = (r_state == S_DONE);
   assign bus.result = r_result;
endmodule

// File: tb/tb_gdiv_datapath.sv
// Self-checking bench for gdiv_datapath: vector table, hand-built handshake corner cases,
// and randomized operands against an arithmetic reference model.
module tb_gdiv_datapath;
   logic clk = 1'b0;
   logic reset;
   int   ntests = 0;
   int   nfail  = 0;

   gdiv_if #(.WIDTH(32)) bus ();
   gdiv_if #(.WIDTH(16)) bus16 ();

   gdiv_datapath #(.WIDTH(32), .ITERS(3)) dut   (.clk(clk), .reset(reset), .bus(bus));
   gdiv_datapath #(.WIDTH(16), .ITERS(1)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] n;
      logic [31:0] d;
      logic [31:0] ia;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Goldschmidt: repeat { N*=K; D*=K; K=2-D } using truncated Q1.(w-1) products.
   function automatic logic [31:0] ref_div(input int w, input int iters,
                                           input longint unsigned n0, d0, k0);
      longint unsigned mask, n, d, k;
      mask = (64'd1 << w) - 64'd1;
      n = n0; d = d0; k = k0;
      for (int i = 0; i < iters; i++) begin
         n = ((n * k) >> (w - 1)) & mask;
         d = ((d * k) >> (w - 1)) & mask;
         k = (64'd0 - d) & mask;
      end
      return n[31:0];
   endfunction

   // Starts at a negedge with the block idle; ends on the negedge of the cycle after done.
   task automatic run_div(input logic [31:0] n, d, ia, output logic [31:0] res,
                          output int nbusy, output int dcyc, output logic dnext);
      bus.start = 1'b1; bus.N = n; bus.D = d; bus.IA = ia;
      @(negedge clk);
      bus.start = 1'b0; bus.N = $urandom; bus.D = $urandom; bus.IA = $urandom;
      nbusy = 0; dcyc = -1; res = '0;
      for (int c = 1; c <= 60; c++) begin
         if (bus.busy) nbusy++;
         if (bus.done) begin
            dcyc = c;
            res  = bus.result;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      dnext = bus.done;
   endtask

   initial begin
      vec_t        vt[5];
      logic [31:0] res, r1, r2, n, d, ia;
      int          nbusy, dcyc, ndone, d1, d2, nd;
      logic        dnext;

      vt[0] = '{32'hC0000000, 32'h80000000, 32'h80000000, 32'hC0000000};
      vt[1] = '{32'h80000000, 32'h80000000, 32'h60000000, 32'h7F800000};
      vt[2] = '{32'h80000000, 32'h80000000, 32'h70000000, 32'h7FF80000};
      vt[3] = '{32'hC0000000, 32'h80000000, 32'h60000000, 32'hBF400000};
      vt[4] = '{32'hE0000000, 32'h80000000, 32'h80000000, 32'hE0000000};

      reset = 1'b1;
      bus.en = 1'b1;   bus.start = 1'b0;   bus.N = '0;   bus.D = '0;   bus.IA = '0;
      bus16.en = 1'b1; bus16.start = 1'b0; bus16.N = '0; bus16.D = '0; bus16.IA = '0;
      #3;
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_result", bus.result, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      foreach (vt[i]) begin
         run_div(vt[i].n, vt[i].d, vt[i].ia, res, nbusy, dcyc, dnext);
         check($sformatf("vec%0d_result", i), res, vt[i].exp);
         check($sformatf("vec%0d_busy_cycles", i), nbusy, 6);
         check($sformatf("vec%0d_done_cycle", i), dcyc, 7);
         check($sformatf("vec%0d_done_drops", i), dnext, 0);
      end

      // Reset during MUL_D of the first iteration aborts the division.
      bus.start = 1'b1; bus.N = 32'h80000000; bus.D = 32'h80000000; bus.IA = 32'h60000000;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("rst_mid_busy_before", bus.busy, 1);
      reset = 1'b1;
      #1;
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_done", bus.done, 0);
      check("rst_mid_result", bus.result, 0);
      @(negedge clk);
      reset = 1'b0;
      nbusy = 0; ndone = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.busy) nbusy++;
         if (bus.done) ndone++;
      end
      check("rst_mid_no_busy_after", nbusy, 0);
      check("rst_mid_no_done_after", ndone, 0);

      // Stall: en low in cycles 1-2 (MUL_N) and 9-11 (DONE).
      bus.start = 1'b1; bus.N = 32'h80000000; bus.D = 32'h80000000; bus.IA = 32'h60000000;
      @(negedge clk);
      bus.start = 1'b0;
      nbusy = 0; ndone = 0; res = '0;
      for (int c = 1; c <= 20; c++) begin
         bus.en = (c == 1 || c == 2 || c == 9 || c == 10 || c == 11) ? 1'b0 : 1'b1;
         if (bus.busy) nbusy++;
         if (bus.done) begin
            ndone++;
            res = bus.result;
         end
         @(negedge clk);
      end
      bus.en = 1'b1;
      check("stall_result", res, 32'h7F800000);
      check("stall_busy_cycles", nbusy, 8);
      check("stall_done_cycles", ndone, 4);

      // Back-to-back: second operand set shows up while busy and waits for DONE.
      bus.start = 1'b1; bus.N = 32'h80000000; bus.D = 32'h80000000; bus.IA = 32'h60000000;
      @(negedge clk);
      bus.N = 32'hC0000000; bus.D = 32'h80000000; bus.IA = 32'h80000000;
      d1 = -1; d2 = -1; r1 = '0; r2 = '0; nd = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.done) begin
            nd++;
            if (nd == 1) begin d1 = c; r1 = bus.result; end
            else begin d2 = c; r2 = bus.result; bus.start = 1'b0; end
         end
         if (nd == 2) break;
         @(negedge clk);
      end
      bus.start = 1'b0;
      @(negedge clk); @(negedge clk);
      check("b2b_first_done_cycle", d1, 7);
      check("b2b_done_spacing", d2 - d1, 7);
      check("b2b_result1", r1, 32'h7F800000);
      check("b2b_result2", r2, 32'hC0000000);
      check("b2b_idle_after", bus.busy, 0);

      // WIDTH=16, ITERS=1.
      bus16.start = 1'b1; bus16.N = 16'h8000; bus16.D = 16'h8000; bus16.IA = 16'h6000;
      @(negedge clk);
      bus16.start = 1'b0;
      dcyc = -1; nbusy = 0; res = '0;
      for (int c = 1; c <= 20; c++) begin
         if (bus16.busy) nbusy++;
         if (bus16.done) begin dcyc = c; res = {16'h0, bus16.result}; break; end
         @(negedge clk);
      end
      @(negedge clk);
      check("w16_done_cycle", dcyc, 3);
      check("w16_busy_cycles", nbusy, 2);
      check("w16_result", res, 32'h6000);

      // Random normalised operands against the reference model.
      for (int i = 0; i < 25; i++) begin
         n  = 32'h80000000 | ($urandom & 32'h7FFFFFFF);
         d  = 32'h80000000 | ($urandom & 32'h7FFFFFFF);
         ia = 32'h40000001 + ($urandom % 32'h40000000);
         run_div(n, d, ia, res, nbusy, dcyc, dnext);
         check($sformatf("rand%0d_result n=%h d=%h ia=%h", i, n, d, ia), res,
               ref_div(32, 3, n, d, ia));
         check($sformatf("rand%0d_done_cycle", i), dcyc, 7);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/gdiv_datapath.md
# gdiv_datapath

Parametrised, iterative Goldschmidt division datapath: the next generation of the single-cycle multiplier-plus-output-register datapath. It accepts a normalised dividend N, divisor D and initial reciprocal approximation IA, then runs a configurable number of refinement iterations on one shared WIDTH×WIDTH multiplier. It returns the quotient through a start/busy/done handshake with a stall enable. It sits between the operand-normalisation/IA-lookup logic and the result writeback.

## Interface
- WIDTH, 32: operand/result width; all values unsigned fixed-point Q1.(WIDTH-1), range [0,2).
- ITERS, 3: number of Goldschmidt iterations; legal range 1..15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  global advance enable (stall when low).
- start  input  1  request a new division; sampled only when accepted (see Operation).
- N  input  WIDTH  dividend, normalised to [1,2).
- D  input  WIDTH  divisor, normalised to [1,2).
- IA  input  WIDTH  initial approximation of 1/D, in (0.5,1].
- busy  output  1  high in MUL_N and MUL_D states.
- done  output  1  high in DONE state.
- result  output  WIDTH  quotient register; holds its value until the next completion.

## Operation
- Registers: Nr, Dr, Kr (WIDTH each), iteration counter cnt ($clog2(ITERS+1) bits), state, result.
- Multiply rule: P = A*B (2·WIDTH bits, Q2.(2W-2)); stored value = P[2W-2:W-1]. Truncate, no rounding; P[2W-1] is discarded (never set for legal inputs).
- K update rule: Kr = (2 − Dr) = two's-complement negate of Dr modulo 2^WIDTH.
- Exactly one multiplier instance; its operand mux selects Nr or Dr against Kr.
- States:
  - IDLE: on en=1 and start=1, load Nr=N, Dr=D, Kr=IA, cnt=0, then go to MUL_N.
  - MUL_N: on en=1, set Nr=Nr*Kr, then go to MUL_D.
  - MUL_D: on en=1, set Dr'=Dr*Kr, Dr=Dr', Kr=2−Dr', cnt=cnt+1.
    - If cnt+1==ITERS, set result=Nr and go to DONE.
    - Otherwise go to MUL_N.
  - DONE: on en=1, go to IDLE. If start=1 on that same edge, load the new operands as in IDLE and go directly to MUL_N (back-to-back).
- en=0: every register holds, including state, cnt, result and outputs.
- start is ignored in MUL_N and MUL_D; the operation in flight is unaffected.
- N, D and IA are sampled only on the accepting edge and may change afterwards.
- Inputs outside their stated ranges give unspecified values but legal state sequencing.

## Timing
- Reset (async assert): state=IDLE; Nr=Dr=Kr=0; cnt=0; result=0; busy=0; done=0.
- Reset deassertion mid-operation: block is in IDLE; the aborted operation never produces done.
- busy and done are decoded from the state register; no combinational path from inputs to outputs.
- Latency with en held high, start accepted at edge 0:
  - busy is high cycles 1..2·ITERS.
  - result updates at edge 2·ITERS.
  - done is high for exactly cycle 2·ITERS+1.
- Throughput: one result per 2·ITERS+1 cycles when start is held high (DONE→MUL_N reload).
- Each en=0 cycle extends the current state by one cycle. In DONE, done stays high until an en=1 edge.

## Test plan
- Reset mid-run: assert reset during MUL_D of iteration 1 -> all outputs 0 immediately, state IDLE, no done pulse afterwards.
- Identity, WIDTH=32, ITERS=3: N=0xC0000000 (1.5), D=0x80000000, IA=0x80000000, start one cycle ->
  - busy high 6 cycles;
  - done high cycle 7 only;
  - result=0xC0000000.
- Convergence: N=0x80000000 (1.0), D=0x80000000, IA=0x60000000 (0.75) ->
  - Kr sequence 0.75, 1.25, 1.0625;
  - result=0x7F800000 (255/256).
- Stall: repeat the convergence case with en low for 2 cycles in MUL_N and 3 cycles in DONE ->
  - result=0x7F800000;
  - done asserted 4 cycles total;
  - busy high 8 cycles.
- Back-to-back plus ignored start:
  - hold start=1 with two operand sets; the second set is presented while busy and must be ignored until DONE;
  - -> two done pulses exactly 7 cycles apart, each with its correct result.
- Parameter sweep: ITERS=1 and WIDTH=16, N=0x8000, D=0x8000, IA=0x6000 -> done in cycle 3, result=0x6000.
